fpu_issue: RTL
==============

# fpu_issue

Issue and return stage on the integer-core side of the FPU. Accepts float instructions from decode, holds them back on float-register RAW hazards with a per-register countdown scoreboard, and drives the FPU instruction word. It also presents the integer operand for int-to-float converts on the cycle the FPU samples it, and captures float-to-int results for integer writeback.

## Interface
- Parameters:
- `FPU_WB_LAT`, 5: cycles from issue until the FPU register write completes. The destination is readable on issue+`FPU_WB_LAT`+1.
- Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `inst_in`  in  32  instruction from decode
- `inst_valid`  in  1  `inst_in` holds a float instruction
- `int_operand`  in  32  integer rs1 value for `inst_in`
- `inst_ready`  out  1  instruction accepted this cycle
- `fpu_inst`  out  32  instruction word to the FPU
- `fpu_from_intreg`  out  32  integer operand to the FPU
- `fpu_enable_ftoi`  in  1  FPU float-to-int result valid
- `fpu_to_intreg`  in  32  FPU float-to-int result
- `int_wb_valid`  out  1  integer writeback strobe
- `int_wb_rd`  out  5  integer destination register
- `int_wb_data`  out  32  integer writeback data
- `ftoi_pending`  out  1  a float-to-int op is in flight (integer hazard hint)

## Operation
- Decode uses `inst[6:0]`, `inst[31:27]`, rs1 `[19:15]`, rs2 `[24:20]`, rd `[11:7]`.
- OP_FP with funct5 ADD/SUB/MUL:
  - reads float rs1 and rs2
  - writes float rd
- OP_FP with funct5 CVT_S_W (itof):
  - reads integer rs1
  - writes float rd
- OP_FP with funct5 CVT_W_S (ftoi):
  - reads float rs1
  - writes integer rd
- FLW writes float rd. FSW reads float rs2. All other encodings read and write nothing.
- Scoreboard: 32 entries, each a 3-bit down-counter.
  - On issue of a float writer, `cnt[rd]` loads `FPU_WB_LAT`.
  - All nonzero counters decrement by 1 every cycle. A reload on the same edge takes priority over the decrement.
- Hazard: a float source whose counter is nonzero.
- `inst_ready` = !hazard. Issue happens when `inst_valid` && `inst_ready`.
- `fpu_inst` is combinational: `inst_in` when issuing, else 32'h0 (bubble, decodes to no-op).
- `fpu_from_intreg` registers `int_operand` on an itof issue and holds its value otherwise.
- ftoi tracking:
  - On issue, the 5-bit rd goes into a 2-deep rd shift register with a valid bit.
  - On a cycle with `fpu_enable_ftoi` high, the head rd and `fpu_to_intreg` are registered into `int_wb_rd`/`int_wb_data`, and `int_wb_valid` pulses for one cycle.
  - `fpu_enable_ftoi` high while the head valid bit is low is ignored and sets a sticky sim-only error flag.
- `ftoi_pending` is high while any ftoi valid bit is set.

## Timing
- Reset values:
  - `inst_ready` reflects an all-zero scoreboard.
  - `fpu_from_intreg`, `int_wb_rd`, `int_wb_data` are 0.
  - `int_wb_valid` and `ftoi_pending` are 0.
  - All counters and valid bits are cleared.
- Issue at cycle t:
  - `fpu_inst` = `inst_in` in cycle t.
  - `fpu_from_intreg` is valid in t+1 (the FPU samples it at t+1).
  - `fpu_enable_ftoi` arrives in t+2.
  - `int_wb_valid` is high in t+3.
- Dependency: a float writer issued at t blocks readers of rd for cycles t+1..t+5. The first allowed issue is t+6. Reloading a ticking counter restarts the wait from the new issue.
- Throughput: one instruction per cycle with no hazard, and back-to-back ftoi issues produce back-to-back writebacks. A writer to the same register as an in-flight writer is not blocked: all ops have equal latency and complete in order.
- Mid-operation reset clears tracking only. Ops already in the FPU still complete and write the float regfile. An `fpu_enable_ftoi` arriving after reset is dropped under the head-valid rule.
- Self-dependency (rd == rs1 on the issuing instruction) checks the old counter value only.

## Structure
- Shared package `fpu_pkg`:
  - opcode constants `OP_FP`, `OP_FLW`, `OP_FSW`
  - funct5 constants `F5_ADD`, `F5_SUB`, `F5_MUL`, `F5_CVT_S_W`, `F5_CVT_W_S`
  - `FPU_WB_LAT`
- Sub-module `fpu_scoreboard`: counter array with two read ports and one set port, returning busy bits.
- Decode and ftoi return path stay in the top module.

## Test plan
- After reset:
  - issue `fadd f3,f1,f2` at t → `fpu_inst` = the instruction at t, and `cnt[3]` = 5 at t+1.
  - `fmul f4,f3,f3` presented at t+1 → `inst_ready` low t+1..t+5, issued at t+6.
- `fcvt.s.w f5,x7` with `int_operand` = 32'h0000_002A → `fpu_from_intreg` = 32'h2A at t+1, held afterwards.
- `fcvt.w.s x9,f1` at t, model `fpu_enable_ftoi` high with 32'h0000_0003 at t+2 → `int_wb_valid` high at t+3 with rd = 9, data = 3; `ftoi_pending` high t+1..t+2.
- Two ftoi (rd 10, 11) on back-to-back cycles → writebacks at t+3 and t+4, in order, with correct rds.
- `flw f2` at t, then `flw f2` again at t+3 → a reader of f2 is blocked until t+9.
- `rst_n` low at t+2 after a writer → `inst_ready` = 1 immediately, and a stray `fpu_enable_ftoi` at t+4 produces no writeback.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, decode types and decode helper for the FPU issue stage.
//   OP_*      : major opcodes recognised by the issue stage
//   F5_*      : funct5 values of OP_FP instructions we handle
//   FPU_WB_LAT: cycles from issue until the FPU register write completes
//   decode()  : classifies an instruction into register read/write intent
package fpu_pkg;

    localparam int unsigned FPU_WB_LAT = 5;
    localparam int unsigned CNT_W      = 3;

    localparam logic [6:0] OP_FP  = 7'b1010011;
    localparam logic [6:0] OP_FLW = 7'b0000111;
    localparam logic [6:0] OP_FSW = 7'b0100111;

    localparam logic [4:0] F5_ADD     = 5'b00000;
    localparam logic [4:0] F5_SUB     = 5'b00001;
    localparam logic [4:0] F5_MUL     = 5'b00010;
    localparam logic [4:0] F5_CVT_W_S = 5'b11000;
    localparam logic [4:0] F5_CVT_S_W = 5'b11010;

    typedef enum logic [2:0] {
        OpNone,
        OpArith,
        OpItof,
        OpFtoi,
        OpLoad,
        OpStore
    } op_kind_e;

    typedef struct packed {
        op_kind_e   kind;
        logic       rd_fs1;  // reads float rs1
        logic       rd_fs2;  // reads float rs2
        logic       wr_fd;   // writes float rd
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d.kind   = OpNone;
        d.rd_fs1 = 1'b0;
        d.rd_fs2 = 1'b0;
        d.wr_fd  = 1'b0;
        d.rs1    = inst[19:15];
        d.rs2    = inst[24:20];
        d.rd     = inst[11:7];
        if (inst[6:0] == OP_FP) begin
            case (inst[31:27])
                F5_ADD, F5_SUB, F5_MUL: begin
                    d.kind   = OpArith;
                    d.rd_fs1 = 1'b1;
                    d.rd_fs2 = 1'b1;
                    d.wr_fd  = 1'b1;
                end
                F5_CVT_S_W: begin
                    // rs1 is an integer register, no float read
                    d.kind  = OpItof;
                    d.wr_fd = 1'b1;
                end
                F5_CVT_W_S: begin
                    d.kind   = OpFtoi;
                    d.rd_fs1 = 1'b1;
                end
                default: d.kind = OpNone;
            endcase
        end else if (inst[6:0] == OP_FLW) begin
            d.kind  = OpLoad;
            d.wr_fd = 1'b1;
        end else if (inst[6:0] == OP_FSW) begin
            d.kind   = OpStore;
            d.rd_fs2 = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: per-float-register countdown scoreboard.
//   clk, rst_n          : clock, async active-low reset (clears all counters)
//   rd_addr_a/rd_addr_b : read ports, busy_a/busy_b high while that counter is nonzero
//   set_en, set_addr    : load counter set_addr with LOAD_VAL on this edge
// Every nonzero counter decrements each cycle; a load on the same edge wins.
module fpu_scoreboard #(
    parameter int unsigned LOAD_VAL = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rd_addr_a,
    input  logic [4:0] rd_addr_b,
    output logic       busy_a,
    output logic       busy_b,
    input  logic       set_en,
    input  logic [4:0] set_addr
);
    import fpu_pkg::*;

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_VAL);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (set_en && (set_addr == 5'(i))) begin
                cnt_d[i] = LOAD_CNT;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Reads see the pre-edge value, so a self-dependent issue checks the old count.
    assign busy_a = (cnt_q[rd_addr_a] != '0);
    assign busy_b = (cnt_q[rd_addr_b] != '0);

endmodule

// File: rtl/fpu_issue.sv
// fpu_issue: integer-core side issue/return stage for the FPU.
//   clk, rst_n       : clock, async active-low reset (clears tracking state only)
//   inst_in          : instruction from decode, inst_valid marks it as a float op
//   int_operand      : integer rs1 value accompanying inst_in
//   inst_ready       : no float RAW hazard; issue = inst_valid && inst_ready
//   fpu_inst         : inst_in on an issue cycle, otherwise 0 (bubble)
//   fpu_from_intreg  : int_operand captured on an itof issue, held otherwise
//   fpu_enable_ftoi  : FPU float-to-int result strobe, fpu_to_intreg its data
//   int_wb_valid/rd/data : registered integer writeback of a ftoi result
//   ftoi_pending     : a ftoi op is in flight between issue and its result
module fpu_issue #(
    parameter int unsigned FPU_WB_LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_in,
    input  logic        inst_valid,
    input  logic [31:0] int_operand,
    output logic        inst_ready,
    output logic [31:0] fpu_inst,
    output logic [31:0] fpu_from_intreg,
    input  logic        fpu_enable_ftoi,
    input  logic [31:0] fpu_to_intreg,
    output logic        int_wb_valid,
    output logic [4:0]  int_wb_rd,
    output logic [31:0] int_wb_data,
    output logic        ftoi_pending
);
    import fpu_pkg::*;

    dec_t dec;
    logic busy_rs1;
    logic busy_rs2;
    logic hazard;
    logic issue;

    assign dec = decode(inst_in);

    fpu_scoreboard #(
        .LOAD_VAL (FPU_WB_LAT)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (dec.rs1),
        .rd_addr_b (dec.rs2),
        .busy_a    (busy_rs1),
        .busy_b    (busy_rs2),
        .set_en    (issue && dec.wr_fd),
        .set_addr  (dec.rd)
    );

    // Same-rd writers never block: equal latency means in-order completion.
    assign hazard     = (dec.rd_fs1 && busy_rs1) || (dec.rd_fs2 && busy_rs2);
    assign inst_ready = !hazard;
    assign issue      = inst_valid && inst_ready;
    assign fpu_inst   = issue ? inst_in : 32'h0;

    // Integer operand for itof, sampled by the FPU the cycle after issue.
    logic [31:0] from_int_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            from_int_q <= '0;
        end else if (issue && (dec.kind == OpItof)) begin
            from_int_q <= int_operand;
        end
    end

    assign fpu_from_intreg = from_int_q;

    // ftoi rd tracking: stage 0 holds the op issued last cycle, stage 1 is the head
    // whose result arrives this cycle. Shifts every cycle, so back-to-back issues
    // line up with back-to-back results.
    logic       s0_v_q, s1_v_q;
    logic [4:0] s0_rd_q, s1_rd_q;
    logic       wb_v_q;
    logic [4:0] wb_rd_q;
    logic [31:0] wb_data_q;
    logic       ftoi_err_q;  // sticky: result strobe with no tracked op (sim visibility)
    logic       accept;

    assign accept = fpu_enable_ftoi && s1_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v_q  <= 1'b0;
            s0_rd_q <= '0;
            s1_v_q  <= 1'b0;
            s1_rd_q <= '0;
        end else begin
            s0_v_q  <= issue && (dec.kind == OpFtoi);
            s0_rd_q <= dec.rd;
            s1_v_q  <= s0_v_q;
            s1_rd_q <= s0_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_v_q    <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_v_q <= accept;
            if (accept) begin
                wb_rd_q   <= s1_rd_q;
                wb_data_q <= fpu_to_intreg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftoi_err_q <= 1'b0;
        end else if (fpu_enable_ftoi && !s1_v_q) begin
            ftoi_err_q <= 1'b1;
        end
    end

    assign int_wb_valid = wb_v_q;
    assign int_wb_rd    = wb_rd_q;
    assign int_wb_data  = wb_data_q;
    assign ftoi_pending = s0_v_q || s1_v_q;

endmodule
